// File: rtl/cabin_lighting_sequencer_if.sv
// Scene request handshake between a cabin controller (master) and the
// lighting sequencer (slave). A request transfers on a clock edge where
// req_valid and req_ready are both high.
interface cabin_lighting_sequencer_if;
  logic       req_valid;
  logic [1:0] req_scene;
  logic       req_ready;

  modport master (
    output req_valid,
    output req_scene,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_scene,
    output req_ready
  );
endinterface

// File: rtl/cabin_lighting_sequencer.sv
// Cabin lighting sequencer: buffers scene requests and ramps the committed
// brightness toward each scene's level in bounded steps. Each step waits for
// an external transition timer; a watchdog flags a sticky fault if the timer
// never answers.
// Optional macro CABIN_LIGHT_REQ_FIFO_EN: 2-entry request FIFO instead of a
// single holding register.
module cabin_lighting_sequencer #(
  parameter logic [7:0]  STEP_SIZE      = 8'h40,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [7:0]  LVL_OFF        = 8'h00,
  parameter logic [7:0]  LVL_NIGHT      = 8'h20,
  parameter logic [7:0]  LVL_CRUISE     = 8'h80,
  parameter logic [7:0]  LVL_BOARD      = 8'hFF
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             en,
  cabin_lighting_sequencer_if.slave        req,
  output logic                             timer_start,
  input  logic                             timer_done,
  input  logic                             fault_clr,
  output logic [7:0]                       light_level,
  output logic                             busy,
  output logic                             fault
);

  localparam int unsigned WdW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StArm, StWait, StApply} state_e;

  state_e           state_q, state_d;
  logic [7:0]       level_q, level_d;
  logic [7:0]       target_q, target_d;
  logic [WdW-1:0]   wd_q, wd_d;
  logic             fault_q, fault_d;

  logic             push, pop, buf_empty, buf_full;
  logic [1:0]       head_scene;

  function automatic logic [7:0] scene_level(input logic [1:0] scene);
    case (scene)
      2'd0:    return LVL_OFF;
      2'd1:    return LVL_NIGHT;
      2'd2:    return LVL_CRUISE;
      default: return LVL_BOARD;
    endcase
  endfunction

  // Move by at most STEP_SIZE and clip at the target, so no overshoot or wrap.
  function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
    logic [7:0] diff;
    if (tgt > cur) begin
      diff = tgt - cur;
      return (diff > STEP_SIZE) ? cur + STEP_SIZE : tgt;
    end else begin
      diff = cur - tgt;
      return (diff > STEP_SIZE) ? cur - STEP_SIZE : tgt;
    end
  endfunction

  // Handshake: ready is forced low during reset and while frozen.
  assign req.req_ready = reset_n & en & ~buf_full;
  assign push          = req.req_valid & req.req_ready;
  assign pop           = (state_q == StIdle) & en & ~buf_empty;

`ifdef CABIN_LIGHT_REQ_FIFO_EN
  logic [1:0] fifo_q [2];
  logic       rd_ptr_q, wr_ptr_q;
  logic [1:0] count_q;

  assign buf_empty  = (count_q == 2'd0);
  assign buf_full   = (count_q == 2'd2);
  assign head_scene = fifo_q[rd_ptr_q];

  // Two-entry request FIFO; simultaneous push and pop keeps occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_q[0] <= 2'd0;
      fifo_q[1] <= 2'd0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= req.req_scene;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      if (push && !pop)      count_q <= count_q + 2'd1;
      else if (pop && !push) count_q <= count_q - 2'd1;
    end
  end
`else
  logic       hold_valid_q;
  logic [1:0] hold_scene_q;

  assign buf_empty  = ~hold_valid_q;
  assign buf_full   = hold_valid_q;
  assign head_scene = hold_scene_q;

  // Single holding register; push only happens when it is empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_valid_q <= 1'b0;
      hold_scene_q <= 2'd0;
    end else begin
      if (pop) hold_valid_q <= 1'b0;
      if (push) begin
        hold_valid_q <= 1'b1;
        hold_scene_q <= req.req_scene;
      end
    end
  end
`endif

  // Sequencer state, brightness, target, watchdog and fault registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      level_q  <= 8'h00;
      target_q <= 8'h00;
      wd_q     <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      target_q <= target_d;
      wd_q     <= wd_d;
      fault_q  <= fault_d;
    end
  end

  // Next-state and timer_start; everything holds while en is low.
  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    target_d    = target_q;
    wd_d        = wd_q;
    fault_d     = fault_q;
    timer_start = 1'b0;

    // A timeout later in this block overrides the clear.
    if (fault_clr) fault_d = 1'b0;

    if (en) begin
      unique case (state_q)
        StIdle: begin
          if (!buf_empty) begin
            target_d = scene_level(head_scene);
            if (target_d != level_q) state_d = StArm;
          end
        end
        StArm: begin
          timer_start = 1'b1;
          wd_d        = '0;
          state_d     = StWait;
        end
        StWait: begin
          if (timer_done) begin
            state_d = StApply;
          end else begin
            wd_d = wd_q + WdW'(1);
            if (wd_d == WdW'(TIMEOUT_CYCLES)) begin
              fault_d  = 1'b1;
              target_d = level_q;
              wd_d     = '0;
              state_d  = StIdle;
            end
          end
        end
        StApply: begin
          level_d = step_toward(level_q, target_q);
          state_d = (level_d == target_q) ? StIdle : StArm;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign light_level = level_q;
  assign busy        = (state_q != StIdle);
  assign fault       = fault_q;

endmodule

// File: doc/cabin_lighting_sequencer.md
CABIN_LIGHTING_SEQUENCER -- requirements
Module: cabin_lighting_sequencer

Interface
REQ-001 Parameter STEP_SIZE, default 8'h40: brightness change per completed transition step.
REQ-002 Parameter TIMEOUT_CYCLES, default 16: maximum cycles spent in WAIT before fault.
REQ-003 Parameters LVL_OFF/LVL_NIGHT/LVL_CRUISE/LVL_BOARD, defaults 8'h00/8'h20/8'h80/8'hFF: target level for scene 0/1/2/3.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  0 = maintenance freeze.
REQ-007 req_valid  input  1  scene request valid.
REQ-008 req_scene  input  2  requested scene id.
REQ-009 req_ready  output  1  request buffer can accept.
REQ-010 timer_start  output  1  1-cycle pulse to downstream transition timer.
REQ-011 timer_done  input  1  1-cycle pulse from timer when delay completes.
REQ-012 fault_clr  input  1  clears fault.
REQ-013 light_level  output  8  current committed cabin brightness.
REQ-014 busy  output  1  1 whenever FSM not IDLE.
REQ-015 fault  output  1  sticky timer-timeout flag.

Function
REQ-016 Request accepted on a clk edge with req_valid=1 and req_ready=1; req_ready = en AND buffer not full.
REQ-017 FSM states IDLE, ARM, WAIT, APPLY; all transitions occur only when en=1.
REQ-018 IDLE: if buffer non-empty, pop oldest scene, load target from scene table; if target==light_level go nowhere (stay IDLE), else go ARM.
REQ-019 ARM: timer_start=1 for exactly this cycle, watchdog cleared, next state WAIT.
REQ-020 WAIT: timer_done=1 -> APPLY; else watchdog increments; watchdog reaching TIMEOUT_CYCLES -> fault=1, target discarded, light_level unchanged, go IDLE.
REQ-021 APPLY: light_level moves toward target by min(STEP_SIZE, |target-light_level|), unsigned 8-bit, never overshoots or wraps; equal after move -> IDLE, else ARM.
REQ-022 timer_done outside WAIT is ignored.
REQ-023 Each step costs 1 (ARM) + timer delay + 1 (APPLY) cycles; pop to first timer_start is 2 cycles.
REQ-024 Requests arriving while busy are buffered and serviced in order after current ramp completes; in-progress ramp is never retargeted.
REQ-025 en=0: state, light_level, watchdog, buffer held; timer_start=0; req_ready=0; timer_done ignored.
REQ-026 fault_clr=1 clears fault next edge; fault set and clear in same cycle -> fault=1.
REQ-027 Simultaneous push and pop in same cycle is legal; occupancy unchanged.

Reset
REQ-028 reset_n=0 immediately forces: state IDLE, light_level=8'h00, target=0, watchdog=0, buffer empty, timer_start=0, busy=0, fault=0.
REQ-029 req_ready=0 while reset_n=0; normal operation from first rising edge after release.
REQ-030 Reset mid-ramp discards target and buffered requests; no timer_start issued during or on release.

Configuration
REQ-031 Macro CABIN_LIGHT_REQ_FIFO_EN defined: request buffer is a 2-entry FIFO; req_ready=0 only when 2 entries held.
REQ-032 Macro undefined: single holding register; req_ready=0 while it is occupied; all other behaviour identical.

Verification
REQ-033 Reset, scene 2, timer done 5 cycles after each start -> two timer_start pulses, light_level 0x00->0x40->0x80, busy falls after second APPLY.
REQ-034 From 0x80 request scene 3 -> levels 0xC0 then 0xFF (last step clipped to 0x3F), no wrap.
REQ-035 Request scene 2 with timer_done never asserted -> fault=1 after 16 WAIT cycles, light_level unchanged, busy=0; fault_clr -> fault=0.
REQ-036 en=0 for 20 cycles during WAIT -> no fault, timer_start=0, level held; done after en=1 -> ramp completes normally.
REQ-037 Three back-to-back requests while busy -> FIFO build: third sees req_ready=0, first two serviced in order; non-FIFO build: second stalls.
REQ-038 reset_n low asynchronously mid-APPLY -> light_level=0x00 and busy=0 before next clk edge; no stale timer_start after release.
